// File: rtl/vga_rect_fill_master.sv
// Second bus master that fills a rectangle of the 160x120 monochrome frame buffer
// through the VGA peripheral's X / Y / data / write-enable register window.
module vga_rect_fill_master #(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter logic [7:0] X_MAX     = 8'd159,
  parameter logic [6:0] Y_MAX     = 7'd119
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic [7:0] X0,
  input  logic [7:0] X1,
  input  logic [6:0] Y0,
  input  logic [6:0] Y1,
  input  logic       COLOUR,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic       BUS_REQ,
  input  logic       BUS_GNT,
  output logic [7:0] BUS_ADDR,
  output logic       BUS_WE,
  inout  wire  [7:0] BUS_DATA
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_W_DATA, S_W_Y, S_W_X, S_W_WEON, S_RUN, S_W_WEOFF, S_FIN
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] x_q, x_d, xl_q, xl_d, xh_q, xh_d;
  logic [6:0] y_q, y_d, yl_q, yl_d, yh_q, yh_d;
  logic       colour_q, colour_d, rst_x_q, rst_x_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d, req_q, req_d;
  logic       wr_en_s, own_s;
  logic [7:0] wr_addr_s, wr_data_s;

  // State and coordinate registers, plus registered status outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      x_q      <= 8'd0;
      xl_q     <= 8'd0;
      xh_q     <= 8'd0;
      y_q      <= 7'd0;
      yl_q     <= 7'd0;
      yh_q     <= 7'd0;
      colour_q <= 1'b0;
      rst_x_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      xl_q     <= xl_d;
      xh_q     <= xh_d;
      y_q      <= y_d;
      yl_q     <= yl_d;
      yh_q     <= yh_d;
      colour_q <= colour_d;
      rst_x_q  <= rst_x_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      req_q    <= req_d;
    end
  end

  // Next-state, counter updates and the bus write selected in each state.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    xl_d      = xl_q;
    xh_d      = xh_q;
    y_d       = y_q;
    yl_d      = yl_q;
    yh_d      = yh_q;
    colour_d  = colour_q;
    rst_x_d   = rst_x_q;
    err_d     = 1'b0;
    wr_en_s   = 1'b0;
    wr_addr_s = BASE_ADDR;
    wr_data_s = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if ((X0 > X_MAX) || (X1 > X_MAX) || (Y0 > Y_MAX) || (Y1 > Y_MAX)) begin
            err_d = 1'b1;
          end else begin
            xl_d     = (X0 < X1) ? X0 : X1;
            xh_d     = (X0 < X1) ? X1 : X0;
            yl_d     = (Y0 < Y1) ? Y0 : Y1;
            yh_d     = (Y0 < Y1) ? Y1 : Y0;
            x_d      = (X0 < X1) ? X0 : X1;
            y_d      = (Y0 < Y1) ? Y0 : Y1;
            colour_d = COLOUR;
            rst_x_d  = 1'b0;
            state_d  = S_REQ;
          end
        end else begin
          err_d = 1'b0;
        end
      end
      S_REQ: state_d = S_W_DATA;
      S_W_DATA: begin
        wr_en_s   = 1'b1;
        wr_addr_s = BASE_ADDR + 8'd2;
        wr_data_s = {7'b0000000, colour_q};
        state_d   = BUS_GNT ? S_W_Y : S_W_DATA;
      end
      S_W_Y: begin
        wr_en_s   = 1'b1;
        wr_addr_s = BASE_ADDR + 8'd1;
        wr_data_s = {1'b0, y_q};
        state_d   = BUS_GNT ? S_W_X : S_W_Y;
      end
      S_W_X: begin
        wr_en_s   = 1'b1;
        wr_data_s = x_q;
        state_d   = BUS_GNT ? S_W_WEON : S_W_X;
      end
      S_W_WEON: begin
        wr_en_s   = 1'b1;
        wr_addr_s = BASE_ADDR + 8'd3;
        wr_data_s = 8'h01;
        state_d   = BUS_GNT ? S_RUN : S_W_WEON;
      end
      // Row change writes Y first, then rewinds X on the following write.
      S_RUN: begin
        if (rst_x_q) begin
          wr_en_s   = 1'b1;
          wr_data_s = xl_q;
          if (BUS_GNT) begin
            x_d     = xl_q;
            rst_x_d = 1'b0;
          end else begin
            x_d = x_q;
          end
        end else if (x_q < xh_q) begin
          wr_en_s   = 1'b1;
          wr_data_s = x_q + 8'd1;
          if (BUS_GNT) begin
            x_d = x_q + 8'd1;
          end else begin
            x_d = x_q;
          end
        end else if (y_q < yh_q) begin
          wr_en_s   = 1'b1;
          wr_addr_s = BASE_ADDR + 8'd1;
          wr_data_s = {1'b0, y_q + 7'd1};
          if (BUS_GNT) begin
            y_d     = y_q + 7'd1;
            rst_x_d = 1'b1;
          end else begin
            y_d = y_q;
          end
        end else begin
          state_d = BUS_GNT ? S_W_WEOFF : S_RUN;
        end
      end
      S_W_WEOFF: begin
        wr_en_s   = 1'b1;
        wr_addr_s = BASE_ADDR + 8'd3;
        wr_data_s = 8'h00;
        state_d   = BUS_GNT ? S_FIN : S_W_WEOFF;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
    req_d  = (state_d != S_IDLE) && (state_d != S_FIN);
  end

  assign own_s    = wr_en_s & BUS_GNT;
  assign BUS_ADDR = own_s ? wr_addr_s : 8'bzzzz_zzzz;
  assign BUS_DATA = own_s ? wr_data_s : 8'bzzzz_zzzz;
  assign BUS_WE   = own_s ? 1'b1 : 1'bz;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign BUS_REQ  = req_q;

endmodule

// File: tb/tb_vga_rect_fill_master.sv
// Directed bench for vga_rect_fill_master: a loop-based write-sequence model and
// a small peripheral/frame-buffer model checked against the bus every cycle.
module tb_vga_rect_fill_master;

  logic       clk = 1'b0;
  logic       rst_n, start, colour, gnt;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic       busy, done, err, req, bus_we;
  logic [7:0] bus_addr;
  wire  [7:0] bus_data;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] trace_q[$];
  logic [15:0] ref_q[$];
  logic        rec_trace = 1'b0;

  logic [7:0] per_x;
  logic [6:0] per_y;
  logic       per_d, per_we;
  logic       fb [0:119][0:159];

  vga_rect_fill_master dut (
    .CLK(clk), .RESET_N(rst_n), .START(start), .X0(x0), .X1(x1), .Y0(y0), .Y1(y1),
    .COLOUR(colour), .BUSY(busy), .DONE(done), .ERR(err), .BUS_REQ(req),
    .BUS_GNT(gnt), .BUS_ADDR(bus_addr), .BUS_WE(bus_we), .BUS_DATA(bus_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  function automatic logic [15:0] wr(input int a, input int d);
    return {a[7:0], d[7:0]};
  endfunction

  // Expected bus writes: setup, row-by-row scan, WE off.
  task automatic build(input int ax0, input int ax1, input int ay0, input int ay1, input logic c);
    int xl, xh, yl, yh;
    xl = (ax0 < ax1) ? ax0 : ax1;  xh = (ax0 < ax1) ? ax1 : ax0;
    yl = (ay0 < ay1) ? ay0 : ay1;  yh = (ay0 < ay1) ? ay1 : ay0;
    exp_q.delete();
    exp_q.push_back(wr('hB2, int'(c)));
    exp_q.push_back(wr('hB1, yl));
    exp_q.push_back(wr('hB0, xl));
    exp_q.push_back(wr('hB3, 1));
    for (int r = yl; r <= yh; r++) begin
      for (int x = xl + 1; x <= xh; x++) exp_q.push_back(wr('hB0, x));
      if (r < yh) begin
        exp_q.push_back(wr('hB1, r + 1));
        exp_q.push_back(wr('hB0, xl));
      end
    end
    exp_q.push_back(wr('hB3, 0));
  endtask

  // Per-cycle bus checker and peripheral model.
  always @(negedge clk) begin
    logic [15:0] w;
    logic must_idle;
    if (rst_n) begin
      must_idle = !gnt || !busy;
      if (must_idle) check("bus released", bus_we === 1'b1, 1'b0);
      if (bus_we === 1'b1 && !must_idle) begin
        if (exp_q.size() == 0) begin
          check("unexpected write", {bus_addr, bus_data}, 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          check("bus write", {bus_addr, bus_data}, w);
        end
        if (rec_trace) trace_q.push_back({bus_addr, bus_data});
        case (bus_addr)
          8'hB0:   per_x  = bus_data;
          8'hB1:   per_y  = bus_data[6:0];
          8'hB2:   per_d  = bus_data[0];
          8'hB3:   per_we = bus_data[0];
          default: per_we = per_we;
        endcase
        if (per_we && per_x < 8'd160 && per_y < 7'd120) fb[per_y][per_x] = per_d;
      end
    end
  end

  task automatic run_fill(input int ax0, input int ax1, input int ay0, input int ay1,
                          input logic c, input int exp_done, input int pause_at, input string tag);
    int cyc, n, ones, bad, xl, xh, yl, yh;
    build(ax0, ax1, ay0, ay1, c);
    n = exp_q.size();
    check({tag, " model length"}, 3 + n + ((pause_at > 0) ? 3 : 0), exp_done);
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++) fb[yy][xx] = 1'b0;
    per_x = 8'd0; per_y = 7'd0; per_d = 1'b0; per_we = 1'b0;
    @(posedge clk); #1;
    x0 = ax0[7:0]; x1 = ax1[7:0]; y0 = ay0[6:0]; y1 = ay1[6:0]; colour = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check({tag, " busy"}, busy, 1'b1);
    check({tag, " req"}, req, 1'b1);
    forever begin
      gnt = !(pause_at > 0 && cyc >= pause_at && cyc < pause_at + 3);
      @(negedge clk);
      if (done || cyc >= 2000) break;
      @(posedge clk); #1;
      cyc++;
    end
    gnt = 1'b1;
    check({tag, " done cycle"}, cyc, exp_done);
    check({tag, " req at done"}, req, 1'b0);
    @(posedge clk); #1;
    check({tag, " done pulse"}, done, 1'b0);
    check({tag, " busy after"}, busy, 1'b0);
    check({tag, " writes left"}, exp_q.size(), 0);
    xl = (ax0 < ax1) ? ax0 : ax1;  xh = (ax0 < ax1) ? ax1 : ax0;
    yl = (ay0 < ay1) ? ay0 : ay1;  yh = (ay0 < ay1) ? ay1 : ay0;
    ones = 0; bad = 0;
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++) begin
        if (fb[yy][xx]) ones++;
        if (xx >= xl && xx <= xh && yy >= yl && yy <= yh && fb[yy][xx] !== c) bad++;
      end
    check({tag, " rect pixels"}, bad, 0);
    check({tag, " pixel count"}, ones, c ? (xh - xl + 1) * (yh - yl + 1) : 0);
  endtask

  task automatic err_case(input int ax0, input int ax1, input int ay0, input int ay1, input string tag);
    exp_q.delete();
    @(posedge clk); #1;
    x0 = ax0[7:0]; x1 = ax1[7:0]; y0 = ay0[6:0]; y1 = ay1[6:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " err"}, err, 1'b1);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " req"}, req, 1'b0);
    @(posedge clk); #1;
    check({tag, " err pulse"}, err, 1'b0);
    check({tag, " busy after"}, busy, 1'b0);
    check({tag, " req after"}, req, 1'b0);
  endtask

  initial begin
    logic [15:0] lit [0:10];
    lit = '{16'hB201, 16'hB114, 16'hB00A, 16'hB301, 16'hB00B, 16'hB00C,
            16'hB115, 16'hB00A, 16'hB00B, 16'hB00C, 16'hB300};
    rst_n = 1'b0; start = 1'b0; gnt = 1'b1; colour = 1'b0;
    x0 = 8'd0; x1 = 8'd0; y0 = 7'd0; y1 = 7'd0;
    #12;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset err", err, 1'b0);
    check("reset req", req, 1'b0);
    check("reset bus", bus_we === 1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    build(10, 12, 20, 21, 1'b1);
    check("model size", exp_q.size(), 11);
    for (int i = 0; i < 11; i++) check("model entry", exp_q[i], lit[i]);
    exp_q.delete();

    run_fill(0, 0, 0, 0, 1'b1, 8, 0, "1x1 origin");
    rec_trace = 1'b1; trace_q.delete();
    run_fill(10, 12, 20, 21, 1'b1, 14, 0, "3x2");
    ref_q = trace_q; trace_q.delete();
    run_fill(12, 10, 21, 20, 1'b1, 14, 0, "3x2 swapped");
    rec_trace = 1'b0;
    check("swapped trace length", trace_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < trace_q.size(); i++)
      check("swapped trace", trace_q[i], ref_q[i]);
    run_fill(10, 12, 20, 21, 1'b1, 17, 7, "3x2 paused");
    run_fill(0, 3, 0, 2, 1'b1, 21, 0, "4x3");
    run_fill(159, 159, 119, 119, 1'b1, 8, 0, "corner pixel");
    run_fill(157, 159, 118, 119, 1'b1, 14, 0, "edge rect");
    run_fill(5, 6, 5, 5, 1'b0, 9, 0, "colour 0");

    err_case(10, 160, 20, 21, "x1 160");
    err_case(10, 12, 120, 21, "y0 120");

    build(10, 12, 20, 21, 1'b1);
    @(posedge clk); #1;
    x0 = 8'd10; x1 = 8'd12; y0 = 7'd20; y1 = 7'd21; colour = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort req", req, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort bus", bus_we === 1'b1, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_fill(10, 12, 20, 21, 1'b1, 14, 0, "after abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_rect_fill_master.md
# vga_rect_fill_master

Bus initiator that fills an axis-aligned rectangle of the 160x120 monochrome frame buffer. It drives the shared 8-bit memory-mapped bus (BUS_DATA/BUS_ADDR/BUS_WE) through the VGA peripheral's four-register window (X, Y, pixel data, write-enable), one bus write per cycle, so the processor does not have to issue per-pixel stores. It sits beside the processor as a second bus master behind an external request/grant arbiter.

## Interface
- BASE_ADDR, 8'hB0: bus address of the VGA X register. Y = +1, data = +2, WE = +3.
- X_MAX, 159: largest legal X.
- Y_MAX, 119: largest legal Y.

- CLK  in  1  system clock; all state updates on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  one-cycle request to begin a fill; sampled only in IDLE
- X0, X1  in  8 each  rectangle corner columns, latched on START
- Y0, Y1  in  7 each  rectangle corner rows, latched on START
- COLOUR  in  1  pixel value, latched on START
- BUSY  out  1  high from the cycle after an accepted START until DONE
- DONE  out  1  one-cycle pulse when the fill completes
- ERR  out  1  one-cycle pulse when START is rejected for an out-of-range coordinate
- BUS_REQ  out  1  bus request to the arbiter
- BUS_GNT  in  1  bus grant from the arbiter
- BUS_ADDR  out  8  tristate; driven only while the block owns the bus
- BUS_WE  out  1  tristate; driven 1 only while the block owns the bus
- BUS_DATA  inout  8  tristate; driven only while the block owns the bus; never read

## Operation
- Owning the bus means BUS_GNT=1 and the state is a write state. When the block owns the bus, it drives BUS_ADDR, BUS_DATA and BUS_WE=1 combinationally. Otherwise all three are 'z'.
- A write state advances only in a cycle where BUS_GNT=1. When BUS_GNT=0, the block holds its state and counters; this is a pause.
- On START in IDLE:
  - If any of X0, X1 > X_MAX or Y0, Y1 > Y_MAX: pulse ERR and stay in IDLE.
  - Otherwise latch xl=min(X0,X1), xh=max(X0,X1), yl=min(Y0,Y1), yh=max(Y0,Y1) and COLOUR. Set x=xl, y=yl and go to REQ.
- START while BUSY is ignored.
- States and bus writes:
  - IDLE
  - REQ: BUS_REQ=1, no write. Go to W_DATA.
  - W_DATA: write base+2 = {7'b0, COLOUR}
  - W_Y: write base+1 = {1'b0, y}
  - W_X: write base+0 = x
  - W_WEON: write base+3 = 8'h01
  - RUN: one write per granted cycle, first matching rule:
    - x<xh: write base+0 = x+1, then x++
    - x==xh and y<yh: write base+1 = y+1, then y++ and set flag rst_x
    - rst_x set: write base+0 = xl, then x=xl and clear rst_x. This rule takes priority over the two above.
    - x==xh and y==yh: go to W_WEOFF with no write
  - W_WEOFF: write base+3 = 8'h00
  - FIN: pulse DONE, BUS_REQ=0, go to IDLE
- BUS_REQ is high in every state except IDLE and FIN.
- Address (xh, y+1) is written twice at each row change. This is harmless because it is inside the rectangle.
- Asynchronous reset mid-fill: immediately go to IDLE, all bus outputs 'z', BUS_REQ/BUSY/DONE/ERR=0. The peripheral WE register may be left at 1; software must clear it.

## Timing
- Reset values: BUSY=0, DONE=0, ERR=0, BUS_REQ=0, bus outputs 'z', state IDLE.
- Let W=xh-xl+1, H=yh-yl+1.
- Granted writes per fill: 4 setup + RUN writes + 1 WE-off. RUN writes = H*(W-1) + 2*(H-1).
- With BUS_GNT held at 1, START at edge 0 gives:
  - REQ during cycle 1
  - first write (W_DATA) in cycle 2
  - DONE high in cycle 2 + N_writes + 1 (one extra RUN cycle for the terminal check)
- Each paused cycle adds exactly one cycle of latency.
- ERR is asserted in the cycle after START. No bus activity occurs on a rejected START.
- BUS_REQ deasserts on the same edge that DONE asserts.

## Test plan
- 1x1 at (0,0), COLOUR=1, GNT=1. Required write sequence: B2=01, B1=00, B0=00, B3=01, B3=00. DONE in cycle 8.
- (10,20)-(12,21), COLOUR=1. Required write sequence:
  - setup: B2=01, B1=14, B0=0A, B3=01
  - RUN: B0=0B, B0=0C, B1=15, B0=0A, B0=0B, B0=0C
  - finish: B3=00
  - total 11 writes; frame buffer pixels (10..12, 20..21) set.
- Swapped corners X0=12, X1=10, Y0=21, Y1=20 produce a bus trace identical to the previous case.
- X1=160 or Y0=120 gives an ERR pulse, BUS_REQ stays 0, bus stays 'z', BUSY stays 0.
- Drop BUS_GNT for 3 cycles during RUN: bus goes 'z' in exactly those cycles, no address is skipped or repeated, DONE arrives 3 cycles late.
- Assert RESET_N=0 during RUN: BUS_REQ and BUSY go 0 and the bus goes 'z' without waiting for a clock edge. A fresh START after release runs a complete fill.
